hall_call_register: RTL
=======================

Name: hall_call_register

Overview:
- Upstream front-end for the lift controller; produces its `d_up` / `d_down` request vectors.
- Synchronises and debounces the raw landing-call buttons on each floor.
- Turns each debounced press into a sticky call bit.
- Clears call bits when the car serves that floor in a matching direction.
- Outputs drive the controller request inputs directly.

Parameters:
- FLOORS, 4, number of landings; width of button and call vectors.
- SYNC_STAGES, 2, flip-flops in each button synchroniser chain (minimum 2).
- DEBOUNCE_CYCLES, 4, consecutive synchronised-high samples needed to accept a press (minimum 1, maximum 15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset. Asserting it clears all state immediately; release is synchronous to clk.
- btn_up  input  FLOORS  raw up-call buttons, asynchronous, bit f = floor f.
- btn_down  input  FLOORS  raw down-call buttons, asynchronous, bit f = floor f.
- car_floor  input  3  binary index of the floor where the car currently stands.
- car_dir  input  2  direction the car will leave in: 00 idle, 01 up, 10 down, 11 treated as idle.
- door_open  input  1  level, high while the car doors are open at car_floor.
- d_up  output  FLOORS  latched up calls, to the controller.
- d_down  output  FLOORS  latched down calls, to the controller.
- call_pending  output  1  OR of all bits of d_up and d_down, registered.

Behaviour:
- Reset:
  - d_up, d_down and call_pending are 0.
  - All synchroniser flops, debounce counters and debounced levels are 0.
  - Reset asserted mid-operation drops all calls in the same instant, without waiting for clk.
- Synchronisation:
  - Each of the 2*FLOORS buttons has its own SYNC_STAGES-deep chain.
  - No raw button input reaches any other logic.
- Debounce, per button:
  - A saturating counter increments on each edge where the synchronised bit is 1.
  - It resets to 0 on any edge where the synchronised bit is 0.
  - The debounced level goes high when the counter reaches DEBOUNCE_CYCLES.
  - The debounced level goes low on the first edge the synchronised bit is 0 (release is not filtered).
- Press event:
  - A press event is a rising edge of the debounced level.
  - A held button produces exactly one event; a new event needs release and a full re-debounce.
- Latency:
  - The call bit is first seen high after clock edge SYNC_STAGES + DEBOUNCE_CYCLES.
  - Edge 1 is the first edge at which the raw button is sampled high.
  - With the defaults, the call is visible after edge 6.
- Service clear (combinational condition, registered result):
  - Applies while door_open=1 and car_floor < FLOORS.
  - d_up[car_floor] is cleared if car_dir is up or idle.
  - d_down[car_floor] is cleared if car_dir is down or idle.
- Call bit priority:
  - Clear beats set on the same edge.
  - A press event for a bit that is being held clear is discarded, not deferred.
  - Presses at other floors, or in the non-matching direction, latch normally during a clear.
- Out-of-range floor: car_floor >= FLOORS clears nothing.
- Call bits otherwise hold their value indefinitely; repeated presses of an already-set call have no effect.
- call_pending is registered from the next-state value of the call vectors. It therefore changes on the same edge as d_up / d_down.
- Glitches: a raw pulse shorter than DEBOUNCE_CYCLES synchronised samples never sets a call.

Test Plan (all at defaults: FLOORS=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4):
- Reset check: hold rst=0 with random buttons toggling -> d_up=0000, d_down=0000, call_pending=0. Release rst, press btn_up[2] for 10 cycles -> d_up=0100 after edge 6, call_pending=1 on the same edge.
- Glitch rejection: btn_down[3] high for 3 cycles, then low -> d_down stays 0000. Then 8 cycles high -> d_down=1000 after edge 6 and stays 1000 after release.
- Directional service:
  - d_up=0100 and d_down=0100 set.
  - car_floor=2, car_dir=01, door_open=1 -> next edge d_up=0000, d_down=0100.
  - car_dir changes to 10 with the door still open -> d_down=0000, call_pending=0.
- Idle clears both: d_up=0001 and d_down=0001, car_floor=0, car_dir=00, door_open=1 -> both bits clear on the next edge. A btn_up[0] press completing debounce while the door is still open -> discarded. The same press after door_open=0 -> d_up=0001.
- Held button / simultaneity:
  - Hold btn_up[1] for 30 cycles -> exactly one set.
  - Serve floor 1 while it is held -> d_up[1]=0 and it does not re-latch until release plus re-debounce.
  - Concurrent press at floor 3 during the floor-1 clear -> d_up=1000.
- Async reset mid-operation: calls 1010/0101 pending, pulse rst low between clock edges -> all outputs 0 immediately. After release, a button still held must re-debounce the full 6 edges before re-latching.

Source files
------------

// File: rtl/hall_call_register.sv
// Hall-call register: synchronises and debounces the landing-call buttons,
// latches each accepted press as a sticky call bit and clears the bit when
// the car serves that floor in a matching direction.

// Per-button front end: synchroniser chain, saturating debounce counter
// and one-cycle press pulse on the rising edge of the debounced level.
module hcr_button #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic press_o
);
    localparam logic [3:0] DEB_CNT = 4'(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   deb_q, deb_d;
    logic                   sync_bit;

    // Next-state: shift the raw button in, count consecutive high samples.
    // The debounced level is derived from the next count so the press pulse
    // fires on the same edge the counter reaches DEBOUNCE_CYCLES.
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], btn_i};
        sync_bit = sync_q[SYNC_STAGES-1];
        cnt_d    = 4'd0;
        deb_d    = 1'b0;
        if (sync_bit) begin
            cnt_d = (cnt_q == DEB_CNT) ? cnt_q : cnt_q + 4'd1;
            deb_d = deb_q | (cnt_d == DEB_CNT);
        end
        press_o = deb_d & ~deb_q;
    end

    // State registers; release of the button drops the level immediately.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            cnt_q  <= 4'd0;
            deb_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            deb_q  <= deb_d;
        end
    end
endmodule

// Top level. car_floor is a 3-bit index, so FLOORS is expected to be <= 8.
module hall_call_register #(
    parameter int FLOORS          = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLOORS-1:0] btn_up,
    input  logic [FLOORS-1:0] btn_down,
    input  logic [2:0]        car_floor,
    input  logic [1:0]        car_dir,
    input  logic              door_open,
    output logic [FLOORS-1:0] d_up,
    output logic [FLOORS-1:0] d_down,
    output logic              call_pending
);
    logic [2*FLOORS-1:0] btn_all;
    logic [2*FLOORS-1:0] press;
    logic [FLOORS-1:0]   ev_up, ev_dn;
    logic [FLOORS-1:0]   clr_up, clr_dn;
    logic [FLOORS-1:0]   up_q, up_d, dn_q, dn_d;
    logic                pend_q, pend_d;

    assign btn_all = {btn_down, btn_up};

    // One synchroniser/debouncer per button: up buttons low, down buttons high.
    genvar g;
    generate
        for (g = 0; g < 2*FLOORS; g++) begin : g_btn
            hcr_button #(
                .SYNC_STAGES    (SYNC_STAGES),
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_btn (
                .clk_i  (clk),
                .rst_ni (rst),
                .btn_i  (btn_all[g]),
                .press_o(press[g])
            );
        end
    endgenerate

    assign ev_up = press[FLOORS-1:0];
    assign ev_dn = press[2*FLOORS-1:FLOORS];

    // Service clear: an out-of-range floor index matches no bit, so it
    // clears nothing. Direction 11 behaves as idle and clears both.
    always_comb begin
        clr_up = '0;
        clr_dn = '0;
        for (int f = 0; f < FLOORS; f++) begin
            if (door_open && (car_floor == 3'(f))) begin
                clr_up[f] = (car_dir != 2'b10);
                clr_dn[f] = (car_dir != 2'b01);
            end
        end
    end

    // Call next-state: clear wins, so a press landing on a cleared bit is lost.
    always_comb begin
        up_d   = (up_q | ev_up) & ~clr_up;
        dn_d   = (dn_q | ev_dn) & ~clr_dn;
        pend_d = |{up_d, dn_d};
    end

    // Call registers; pending tracks the same next-state so it moves together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            up_q   <= '0;
            dn_q   <= '0;
            pend_q <= 1'b0;
        end else begin
            up_q   <= up_d;
            dn_q   <= dn_d;
            pend_q <= pend_d;
        end
    end

    assign d_up         = up_q;
    assign d_down       = dn_q;
    assign call_pending = pend_q;
endmodule
